// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the writeback queue (register address width, queued entry layout).
package wb_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-valid-entry search over the queue for a decode-stage read address.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                    ent_i [DEPTH],
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [$clog2(DEPTH)-1:0]     wr_i,
  input  logic [REG_ADDR_W-1:0]        raddr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // Walk oldest to youngest starting at the write pointer so the last match wins.
  always_comb begin
    hit_o = 1'b0;
    data_o = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = wr_i + PW'(i);
      if (vld_i[idx] && ent_i[idx].addr == raddr_i) begin
        hit_o = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: FIFO between execute results and the shared register-file write port.
// Define WB_QUEUE_FWD_EN to forward queued, not-yet-written values to decode.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [REG_ADDR_W-1:0]      in_addr,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       rf_port_free,
  output logic                       rf_we,
  output logic [REG_ADDR_W-1:0]      rf_waddr,
  output logic [WIDTH-1:0]           rf_wdata,
  input  logic [REG_ADDR_W-1:0]      fwd_raddr,
  output logic                       fwd_hit,
  output logic [WIDTH-1:0]           fwd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop, empty;
  assign empty = cnt_q == '0;
  assign in_ready = reset && cnt_q != CW'(DEPTH);
  assign rf_we = reset && !empty && rf_port_free;
  assign push = in_valid && in_ready;
  assign pop = rf_we;
  assign rf_waddr = empty ? '0 : mem_q[rd_q].addr;
  assign rf_wdata = empty ? '0 : mem_q[rd_q].data;
  assign count = cnt_q;
  assign wr_d = push ? wr_q + 1'b1 : wr_q;
  assign rd_d = pop ? rd_q + 1'b1 : rd_q;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  // Push and pop never share a slot: that needs both empty and full at once.
  always_comb begin
    vld_d = vld_q;
    if (pop) vld_d[rd_q] = 1'b0;
    if (push) vld_d[wr_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{addr: in_addr, data: in_data};
  end
`ifdef WB_QUEUE_FWD_EN
  logic hit;
  logic [DATA_W-1:0] hit_data;
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .ent_i  (mem_q),
    .vld_i  (vld_q),
    .wr_i   (wr_q),
    .raddr_i(fwd_raddr),
    .hit_o  (hit),
    .data_o (hit_data)
  );
  assign fwd_hit = reset && hit;
  assign fwd_data = fwd_hit ? hit_data : '0;
`else
  logic fwd_unused;
  assign fwd_unused = ^{fwd_raddr, vld_q};
  assign fwd_hit = 1'b0;
  assign fwd_data = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: randomized bench checking the writeback queue against a queue-based reference.
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  typedef struct packed {logic [3:0] a; logic [7:0] d;} ent_t;
  logic clk = 0, reset = 0, in_valid = 0, rf_port_free = 0;
  logic [3:0] in_addr = 0, fwd_raddr = 0;
  logic [7:0] in_data = 0;
  logic in_ready, rf_we, fwd_hit;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata, fwd_data;
  logic [2:0] count;
  int total = 0, bad = 0;
  ent_t mq[$], exp_log[$], obs_log[$];

  wb_write_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .rf_port_free(rf_port_free), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference: plain FIFO of entries; pop the head when free, push when fewer than DEPTH held.
  task automatic tick();
    bit pop, push;
    ent_t e;
    #1;
    pop = reset && mq.size() != 0 && rf_port_free;
    push = reset && in_valid && mq.size() < DEPTH;
    e = '{a: in_addr, d: in_data};
    if (pop) exp_log.push_back(mq[0]);
    if (rf_we === 1'b1) obs_log.push_back('{a: rf_waddr, d: rf_wdata});
    @(posedge clk);
    if (!reset) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    #1;
  endtask

  function automatic void exp_fwd(input logic [3:0] r, output logic h, output logic [7:0] d);
    h = 0;
    d = 0;
`ifdef WB_QUEUE_FWD_EN
    if (reset) foreach (mq[i]) if (mq[i].a == r) begin h = 1; d = mq[i].d; end
`else
    if (r === 4'bx) h = 0;
`endif
  endfunction

  task automatic test_reset();
    reset = 0; in_valid = 0; rf_port_free = 1;
    repeat (2) begin
      tick();
      total++;
      if (in_ready !== 0 || rf_we !== 0 || fwd_hit !== 0) begin
        bad++; $display("FAIL reset_outputs got ready=%b we=%b hit=%b exp 0/0/0", in_ready, rf_we, fwd_hit);
      end
    end
    reset = 1;
    repeat (10) begin
      tick();
      total++;
      if (in_ready !== 1 || count !== 0 || rf_we !== 0) begin
        bad++; $display("FAIL idle got ready=%b count=%0d we=%b exp 1/0/0", in_ready, count, rf_we);
      end
    end
    rf_port_free = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_addr = 4'(i + 1); in_data = 8'($urandom); tick();
    end
    in_valid = 0;
    total++;
    if (count !== 2) begin bad++; $display("FAIL reset_prefill got count=%0d exp 2", count); end
    reset = 0; tick(); reset = 1; rf_port_free = 1; #1;
    total++;
    if (count !== 0 || rf_we !== 0 || rf_waddr !== 0 || rf_wdata !== 0) begin
      bad++; $display("FAIL reset_discard got count=%0d we=%b addr=%0d data=%0h exp 0/0/0/0", count, rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_basic();
    rf_port_free = 1; in_valid = 1; in_addr = 3; in_data = 8'h11; #1;
    total++;
    if (rf_we !== 0) begin bad++; $display("FAIL no_bypass got we=%b exp 0", rf_we); end
    tick();
    in_addr = 5; in_data = 8'h22; #1;
    total++;
    if (rf_we !== 1 || rf_waddr !== 3 || rf_wdata !== 8'h11) begin
      bad++; $display("FAIL basic_first got we=%b addr=%0d data=%0h exp 1/3/11", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    in_valid = 0; #1;
    total++;
    if (rf_we !== 1 || rf_waddr !== 5 || rf_wdata !== 8'h22) begin
      bad++; $display("FAIL basic_second got we=%b addr=%0d data=%0h exp 1/5/22", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    total++;
    if (count !== 0 || rf_we !== 0) begin bad++; $display("FAIL basic_empty got count=%0d we=%b exp 0/0", count, rf_we); end
  endtask

  task automatic test_full();
    rf_port_free = 0; in_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      in_addr = 4'($urandom); in_data = 8'($urandom); tick();
    end
    in_addr = 4'hf; in_data = 8'hff; #1;
    total++;
    if (count !== 4 || in_ready !== 0) begin bad++; $display("FAIL full got count=%0d ready=%b exp 4/0", count, in_ready); end
    tick();
    total++;
    if (count !== 4 || rf_waddr !== mq[0].a || rf_wdata !== mq[0].d) begin
      bad++; $display("FAIL full_ignore got count=%0d head=%0d/%0h exp 4/%0d/%0h", count, rf_waddr, rf_wdata, mq[0].a, mq[0].d);
    end
    in_valid = 0; rf_port_free = 1; #1;
    total++;
    if (rf_we !== 1 || in_ready !== 0) begin bad++; $display("FAIL full_first_pop got we=%b ready=%b exp 1/0", rf_we, in_ready); end
    tick();
    total++;
    if (in_ready !== 1) begin bad++; $display("FAIL full_ready_after_pop got %b exp 1", in_ready); end
    for (int i = 0; i < DEPTH && mq.size() != 0; i++) begin
      total++;
      if (rf_we !== 1 || rf_waddr !== mq[0].a || rf_wdata !== mq[0].d) begin
        bad++; $display("FAIL full_drain got we=%b %0d/%0h exp 1/%0d/%0h", rf_we, rf_waddr, rf_wdata, mq[0].a, mq[0].d);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    rf_port_free = 0; in_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      in_addr = 4'($urandom); in_data = 8'($urandom); tick();
    end
    rf_port_free = 1;
    for (int i = 0; i < 24; i++) begin
      bit acc;
      #1;
      total++;
      if (rf_we !== 1 || rf_waddr !== mq[0].a || rf_wdata !== mq[0].d || in_ready !== (mq.size() < DEPTH)) begin
        bad++; $display("FAIL wrap got we=%b %0d/%0h ready=%b exp 1/%0d/%0h/%b", rf_we, rf_waddr, rf_wdata, in_ready, mq[0].a, mq[0].d, mq.size() < DEPTH);
      end
      acc = mq.size() < DEPTH;
      tick();
      if (acc) begin pushed++; in_addr = 4'($urandom); in_data = 8'($urandom); end
    end
    total++;
    if (pushed < 10) begin bad++; $display("FAIL wrap_pushes got %0d exp >=10", pushed); end
    in_valid = 0;
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) tick();
    total++;
    if (count !== 0) begin bad++; $display("FAIL wrap_drain got count=%0d exp 0", count); end
  endtask

  task automatic test_fwd();
    logic h;
    logic [7:0] d;
    rf_port_free = 0; in_valid = 1;
    in_addr = 7; in_data = 8'haa; tick();
    in_addr = 7; in_data = 8'hbb; tick();
    in_addr = 7; in_data = 8'hcc; fwd_raddr = 7; #1;
    exp_fwd(7, h, d);
    total++;
    if (fwd_hit !== h || fwd_data !== d) begin bad++; $display("FAIL fwd_youngest got %b/%0h exp %b/%0h", fwd_hit, fwd_data, h, d); end
    in_valid = 0; fwd_raddr = 2; #1;
    total++;
    if (fwd_hit !== 0 || fwd_data !== 0) begin bad++; $display("FAIL fwd_miss got %b/%0h exp 0/0", fwd_hit, fwd_data); end
    fwd_raddr = 7; rf_port_free = 1;
    for (int i = 0; i < DEPTH && mq.size() != 0; i++) begin
      #1;
      exp_fwd(7, h, d);
      total++;
      if (fwd_hit !== h || fwd_data !== d) begin bad++; $display("FAIL fwd_drain got %b/%0h exp %b/%0h", fwd_hit, fwd_data, h, d); end
      tick();
    end
  endtask

  task automatic test_same_addr();
    rf_port_free = 0; in_valid = 1;
    in_addr = 9; in_data = 8'h01; tick();
    in_addr = 9; in_data = 8'h02; tick();
    in_valid = 0; rf_port_free = 1; #1;
    total++;
    if (rf_we !== 1 || rf_waddr !== 9 || rf_wdata !== 8'h01) begin bad++; $display("FAIL same_first got %b %0d/%0h exp 1 9/01", rf_we, rf_waddr, rf_wdata); end
    tick();
    total++;
    if (rf_we !== 1 || rf_waddr !== 9 || rf_wdata !== 8'h02) begin bad++; $display("FAIL same_second got %b %0d/%0h exp 1 9/02", rf_we, rf_waddr, rf_wdata); end
    tick();
    total++;
    if (count !== 0) begin bad++; $display("FAIL same_empty got count=%0d exp 0", count); end
  endtask

  task automatic test_random();
    logic h;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 49) != 0;
      in_valid = $urandom_range(0, 2) != 0;
      rf_port_free = $urandom_range(0, 2) == 0;
      in_addr = 4'($urandom_range(0, 3));
      in_data = 8'($urandom);
      fwd_raddr = 4'($urandom_range(0, 3));
      #1;
      exp_fwd(fwd_raddr, h, d);
      total++;
      if (count !== 3'(mq.size()) || in_ready !== (reset && mq.size() < DEPTH)
          || rf_we !== (reset && mq.size() != 0 && rf_port_free)
          || rf_waddr !== (mq.size() != 0 ? mq[0].a : 4'h0)
          || rf_wdata !== (mq.size() != 0 ? mq[0].d : 8'h0)
          || fwd_hit !== h || fwd_data !== d) begin
        bad++;
        $display("FAIL random cyc=%0d got cnt=%0d rdy=%b we=%b %0d/%0h fwd=%b/%0h exp cnt=%0d fwd=%b/%0h",
                 i, count, in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, mq.size(), h, d);
      end
      tick();
    end
    reset = 1; in_valid = 0; rf_port_free = 1;
    for (int i = 0; i < 2 * DEPTH; i++) tick();
  endtask

  task automatic test_scoreboard();
    total++;
    if (obs_log.size() != exp_log.size()) begin
      bad++; $display("FAIL write_count got %0d exp %0d", obs_log.size(), exp_log.size());
    end
    for (int i = 0; i < obs_log.size() && i < exp_log.size(); i++) begin
      total++;
      if (obs_log[i] !== exp_log[i]) begin
        bad++; $display("FAIL write_order idx=%0d got %0d/%0h exp %0d/%0h", i, obs_log[i].a, obs_log[i].d, exp_log[i].a, exp_log[i].d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_fwd();
    test_same_addr();
    test_random();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
